// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared funct3 codes, FSM states and decode helpers for lsu_mc
// Exports: F3_* funct3 codes, lsu_state_e, lsu_size_bytes(), lsu_f3_legal().
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_e;

    // Access size in bytes; funct3[2] only selects sign vs zero extension.
    function automatic logic [3:0] lsu_size_bytes(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 4'd1;
            2'b01:   return 4'd2;
            2'b10:   return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

    // Unsigned forms are load-only; D and WU exist only on a 64-bit datapath.
    function automatic logic lsu_f3_legal(input logic [2:0] f3, input logic store,
                                          input logic xlen64);
        if (f3 == 3'b111)
            return 1'b0;
        if (store && f3[2])
            return 1'b0;
        if (!xlen64 && (f3 == F3_D || f3 == F3_WU))
            return 1'b0;
        return 1'b1;
    endfunction

endpackage

// File: rtl/lsu_mc_align.sv
// rtl/lsu_mc_align.sv - combinational store lane/strobe shifter and load extract/extend
// Ports: offset/size/sgn describe the access; wdata -> st_{lo,hi}_{data,strb} (beat 0/1 halves);
//        beat0/beat1 bus words -> ld_data (aligned, extended to XLEN).
module lsu_align #(
    parameter int XLEN  = 32,
    parameter int OFF_W = $clog2(XLEN / 8)
) (
    input  logic [OFF_W-1:0]  offset,
    input  logic [3:0]        size,
    input  logic              sgn,
    input  logic [XLEN-1:0]   wdata,
    input  logic [XLEN-1:0]   beat0,
    input  logic [XLEN-1:0]   beat1,
    output logic [XLEN-1:0]   st_lo_data,
    output logic [XLEN-1:0]   st_hi_data,
    output logic [XLEN/8-1:0] st_lo_strb,
    output logic [XLEN/8-1:0] st_hi_strb,
    output logic [XLEN-1:0]   ld_data
);
    localparam int NB = XLEN / 8;

    logic [2*XLEN-1:0] wide_data;
    logic [2*NB-1:0]   base_mask;
    logic [2*NB-1:0]   wide_mask;
    logic [XLEN-1:0]   shr;
    logic              sign_bit;

    always_comb begin
        // Store: shift the right-justified value across a double-width window so
        // a line-crossing access naturally spills into the second beat.
        wide_data = {{XLEN{1'b0}}, wdata} << {offset, 3'b000};
        base_mask = '0;
        for (int i = 0; i < 2 * NB; i++)
            base_mask[i] = (i < int'(size));
        wide_mask  = base_mask << offset;
        st_lo_data = wide_data[XLEN-1:0];
        st_hi_data = wide_data[2*XLEN-1:XLEN];
        st_lo_strb = wide_mask[NB-1:0];
        st_hi_strb = wide_mask[2*NB-1:NB];

        // Load: bring the addressed byte to lane 0, then extend above S bytes.
        shr = XLEN'({beat1, beat0} >> {offset, 3'b000});
        case (size)
            4'd1:    sign_bit = shr[7];
            4'd2:    sign_bit = shr[15];
            4'd4:    sign_bit = shr[31];
            default: sign_bit = shr[XLEN-1];
        endcase
        ld_data = '0;
        for (int i = 0; i < XLEN; i++)
            ld_data[i] = (i < 8 * int'(size)) ? shr[i] : (sgn & sign_bit);
    end

endmodule

// File: rtl/lsu_mc.sv
// rtl/lsu_mc.sv - multi-cycle load/store unit: core request -> req/gnt/rvalid bus -> registered response
// Ports: req_* core request (ready only in IDLE); resp_* one-cycle response pulse;
//        mem_* bus request held until mem_gnt, mem_rvalid/mem_rdata/mem_err response per beat.
module lsu_mc #(
    parameter int XLEN           = 32,
    parameter int ADDR_W         = 32,
    parameter int MISALIGN_SPLIT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_fault,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_strb,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_err
);
    import lsu_pkg::*;

    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);

    lsu_state_e        state;
    logic              op_store;
    logic              op_sgn;
    logic              op_split;
    logic              beat;
    logic [3:0]        op_size;
    logic [OFF_W-1:0]  op_off;
    logic [ADDR_W-1:0] op_base;
    logic [XLEN-1:0]   op_wdata;
    logic [XLEN-1:0]   rbuf0;

    logic [3:0]        req_size;
    logic [OFF_W-1:0]  req_off;
    logic              req_legal;
    logic              req_split;
    logic [ADDR_W-1:0] req_base;

    logic              a_idle;
    logic [OFF_W-1:0]  a_off;
    logic [3:0]        a_size;
    logic              a_sgn;
    logic [XLEN-1:0]   a_wdata;
    logic [XLEN-1:0]   a_beat0;
    logic [XLEN-1:0]   a_beat1;
    logic [XLEN-1:0]   st_lo_data;
    logic [XLEN-1:0]   st_hi_data;
    logic [NB-1:0]     st_lo_strb;
    logic [NB-1:0]     st_hi_strb;
    logic [XLEN-1:0]   ld_data;

    assign req_size  = lsu_size_bytes(req_funct3);
    assign req_off   = req_addr[OFF_W-1:0];
    assign req_legal = lsu_f3_legal(req_funct3, req_store, XLEN == 64);
    assign req_split = (int'(req_off) + int'(req_size)) > NB;
    assign req_base  = req_addr & ~ADDR_W'(NB - 1);

    // In IDLE the aligner sees the incoming request so beat 0 lanes can be
    // registered on accept; afterwards it works from the latched operation.
    assign a_idle  = (state == ST_IDLE);
    assign a_off   = a_idle ? req_off : op_off;
    assign a_size  = a_idle ? req_size : op_size;
    assign a_sgn   = a_idle ? ~req_funct3[2] : op_sgn;
    assign a_wdata = a_idle ? req_wdata : op_wdata;
    // The final beat's data goes straight from the bus into the assembler.
    assign a_beat0 = beat ? rbuf0 : mem_rdata;
    assign a_beat1 = beat ? mem_rdata : '0;

    lsu_align #(.XLEN(XLEN), .OFF_W(OFF_W)) u_align (
        .offset     (a_off),
        .size       (a_size),
        .sgn        (a_sgn),
        .wdata      (a_wdata),
        .beat0      (a_beat0),
        .beat1      (a_beat1),
        .st_lo_data (st_lo_data),
        .st_hi_data (st_hi_data),
        .st_lo_strb (st_lo_strb),
        .st_hi_strb (st_hi_strb),
        .ld_data    (ld_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_fault <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_strb   <= '0;
            beat       <= 1'b0;
            op_store   <= 1'b0;
            op_sgn     <= 1'b0;
            op_split   <= 1'b0;
            op_size    <= '0;
            op_off     <= '0;
            op_base    <= '0;
            op_wdata   <= '0;
            rbuf0      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        op_store  <= req_store;
                        op_sgn    <= ~req_funct3[2];
                        op_split  <= req_split;
                        op_size   <= req_size;
                        op_off    <= req_off;
                        op_base   <= req_base;
                        op_wdata  <= req_wdata;
                        beat      <= 1'b0;
                        req_ready <= 1'b0;
                        if (!req_legal || (req_split && MISALIGN_SPLIT == 0)) begin
                            state      <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_fault <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            state     <= ST_ISSUE;
                            mem_req   <= 1'b1;
                            mem_we    <= req_store;
                            mem_addr  <= req_base;
                            mem_wdata <= req_store ? st_lo_data : '0;
                            mem_strb  <= req_store ? st_lo_strb : '0;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (mem_gnt) begin
                        state     <= ST_WAIT;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_wdata <= '0;
                        mem_strb  <= '0;
                    end
                end
                ST_WAIT: begin
                    if (mem_rvalid) begin
                        if (mem_err) begin
                            state      <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_fault <= 1'b1;
                            resp_rdata <= '0;
                        end else if (op_split && !beat) begin
                            state     <= ST_ISSUE;
                            beat      <= 1'b1;
                            rbuf0     <= mem_rdata;
                            mem_req   <= 1'b1;
                            mem_we    <= op_store;
                            mem_addr  <= op_base + ADDR_W'(NB);
                            mem_wdata <= op_store ? st_hi_data : '0;
                            mem_strb  <= op_store ? st_hi_strb : '0;
                        end else begin
                            state      <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_fault <= 1'b0;
                            resp_rdata <= op_store ? '0 : ld_data;
                        end
                    end
                end
                ST_RESP: begin
                    state      <= ST_IDLE;
                    resp_valid <= 1'b0;
                    resp_fault <= 1'b0;
                    resp_rdata <= '0;
                    req_ready  <= 1'b1;
                    beat       <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mc.sv
// tb/tb_lsu_mc.sv - directed self-checking bench for lsu_mc (XLEN=32 split/no-split, XLEN=64)
module tb_lsu_mc;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // XLEN=32, MISALIGN_SPLIT=1
    logic        req_valid = 0, req_store = 0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, resp_valid, resp_fault;
    logic [31:0] resp_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_strb;
    logic        mem_gnt = 0, mem_rvalid = 0, mem_err = 0;
    logic [31:0] mem_rdata = '0;

    // XLEN=32, MISALIGN_SPLIT=0
    logic        n_req_valid = 0, n_req_store = 0;
    logic [2:0]  n_req_funct3 = '0;
    logic [31:0] n_req_addr = '0, n_req_wdata = '0;
    logic        n_req_ready, n_resp_valid, n_resp_fault;
    logic [31:0] n_resp_rdata;
    logic        n_mem_req, n_mem_we;
    logic [31:0] n_mem_addr, n_mem_wdata;
    logic [3:0]  n_mem_strb;
    logic        n_mem_gnt = 0, n_mem_rvalid = 0, n_mem_err = 0;
    logic [31:0] n_mem_rdata = '0;

    // XLEN=64, MISALIGN_SPLIT=1
    logic        w_req_valid = 0, w_req_store = 0;
    logic [2:0]  w_req_funct3 = '0;
    logic [31:0] w_req_addr = '0;
    logic [63:0] w_req_wdata = '0;
    logic        w_req_ready, w_resp_valid, w_resp_fault;
    logic [63:0] w_resp_rdata;
    logic        w_mem_req, w_mem_we;
    logic [31:0] w_mem_addr;
    logic [63:0] w_mem_wdata;
    logic [7:0]  w_mem_strb;
    logic        w_mem_gnt = 0, w_mem_rvalid = 0, w_mem_err = 0;
    logic [63:0] w_mem_rdata = '0;

    lsu_mc #(.XLEN(32), .ADDR_W(32), .MISALIGN_SPLIT(1)) dut32 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_strb(mem_strb), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .mem_err(mem_err)
    );

    lsu_mc #(.XLEN(32), .ADDR_W(32), .MISALIGN_SPLIT(0)) dut32n (
        .clk(clk), .rst_n(rst_n),
        .req_valid(n_req_valid), .req_ready(n_req_ready), .req_store(n_req_store),
        .req_funct3(n_req_funct3), .req_addr(n_req_addr), .req_wdata(n_req_wdata),
        .resp_valid(n_resp_valid), .resp_rdata(n_resp_rdata), .resp_fault(n_resp_fault),
        .mem_req(n_mem_req), .mem_we(n_mem_we), .mem_addr(n_mem_addr), .mem_wdata(n_mem_wdata),
        .mem_strb(n_mem_strb), .mem_gnt(n_mem_gnt), .mem_rvalid(n_mem_rvalid),
        .mem_rdata(n_mem_rdata), .mem_err(n_mem_err)
    );

    lsu_mc #(.XLEN(64), .ADDR_W(32), .MISALIGN_SPLIT(1)) dut64 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(w_req_valid), .req_ready(w_req_ready), .req_store(w_req_store),
        .req_funct3(w_req_funct3), .req_addr(w_req_addr), .req_wdata(w_req_wdata),
        .resp_valid(w_resp_valid), .resp_rdata(w_resp_rdata), .resp_fault(w_resp_fault),
        .mem_req(w_mem_req), .mem_we(w_mem_we), .mem_addr(w_mem_addr), .mem_wdata(w_mem_wdata),
        .mem_strb(w_mem_strb), .mem_gnt(w_mem_gnt), .mem_rvalid(w_mem_rvalid),
        .mem_rdata(w_mem_rdata), .mem_err(w_mem_err)
    );

    // Results of the last run32 transaction (cycle numbers counted from accept).
    int          r_cyc;
    logic [31:0] r_data;
    logic        r_fault;
    int          nbeats;
    logic [31:0] b_addr [4];
    logic [31:0] b_wdata[4];
    logic [3:0]  b_strb [4];
    logic        b_we   [4];

    // Issues one request to dut32 and plays a bus that grants immediately and
    // returns read data / ack the cycle after each grant.
    task automatic run32(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] d0, input logic [31:0] d1,
                         input logic err0);
        logic pend, pend_nx;
        int   nrv;
        pend = 0; nrv = 0; nbeats = 0; r_cyc = -1; r_data = 'x; r_fault = 1'bx;
        @(negedge clk);
        req_valid = 1; req_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        @(negedge clk);
        req_valid = 0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            if (resp_valid) begin
                r_cyc = cyc; r_data = resp_rdata; r_fault = resp_fault;
                break;
            end
            pend_nx = 0; mem_gnt = 0; mem_rvalid = 0; mem_err = 0;
            if (mem_req) begin
                if (nbeats < 4) begin
                    b_addr[nbeats] = mem_addr; b_wdata[nbeats] = mem_wdata;
                    b_strb[nbeats] = mem_strb; b_we[nbeats] = mem_we;
                end
                nbeats++;
                mem_gnt = 1; pend_nx = 1;
            end
            if (pend) begin
                mem_rvalid = 1;
                mem_rdata = (nrv == 0) ? d0 : d1;
                mem_err = err0 && (nrv == 0);
                nrv++;
            end
            pend = pend_nx;
            @(negedge clk);
        end
        mem_gnt = 0; mem_rvalid = 0; mem_err = 0;
    endtask

    task automatic test_reset;
        #1;
        n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", req_ready); end
        n_tests++; if (resp_valid !== 1'b0 || resp_fault !== 1'b0 || resp_rdata !== 32'h0) begin
            n_fail++; $display("FAIL reset_resp got v=%b f=%b d=%h exp 0", resp_valid, resp_fault, resp_rdata); end
        n_tests++; if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_strb !== 4'h0) begin
            n_fail++; $display("FAIL reset_mem got req=%b we=%b strb=%b exp 0", mem_req, mem_we, mem_strb); end
        n_tests++; if (w_req_ready !== 1'b1 || w_mem_req !== 1'b0) begin
            n_fail++; $display("FAIL reset_64 got ready=%b req=%b exp 1/0", w_req_ready, w_mem_req); end
    endtask

    task automatic test_sb;
        run32(1, 3'b000, 32'h103, 32'hAB, 32'h0, 32'h0, 0);
        n_tests++; if (nbeats !== 1 || b_addr[0] !== 32'h100 || b_we[0] !== 1'b1) begin
            n_fail++; $display("FAIL sb_bus got beats=%0d addr=%h we=%b exp 1/00000100/1", nbeats, b_addr[0], b_we[0]); end
        n_tests++; if (b_strb[0] !== 4'b1000 || b_wdata[0] !== 32'hAB000000) begin
            n_fail++; $display("FAIL sb_lanes got strb=%b wdata=%h exp 1000/ab000000", b_strb[0], b_wdata[0]); end
        n_tests++; if (r_cyc !== 3 || r_fault !== 1'b0 || r_data !== 32'h0) begin
            n_fail++; $display("FAIL sb_resp got cyc=%0d f=%b d=%h exp 3/0/0", r_cyc, r_fault, r_data); end
        @(negedge clk);
        n_tests++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++; $display("FAIL resp_pulse got v=%b ready=%b exp 0/1", resp_valid, req_ready); end
    endtask

    task automatic test_lb_lbu;
        run32(0, 3'b000, 32'h102, 32'h0, 32'h00800000, 32'h0, 0);
        n_tests++; if (b_strb[0] !== 4'b0000 || b_we[0] !== 1'b0 || b_addr[0] !== 32'h100) begin
            n_fail++; $display("FAIL lb_bus got strb=%b we=%b addr=%h exp 0000/0/00000100", b_strb[0], b_we[0], b_addr[0]); end
        n_tests++; if (r_data !== 32'hFFFFFF80 || r_cyc !== 3) begin
            n_fail++; $display("FAIL lb_data got %h cyc=%0d exp ffffff80/3", r_data, r_cyc); end
        run32(0, 3'b100, 32'h102, 32'h0, 32'h00800000, 32'h0, 0);
        n_tests++; if (r_data !== 32'h00000080) begin
            n_fail++; $display("FAIL lbu_data got %h exp 00000080", r_data); end
        // In-word misaligned halfword stays single beat.
        run32(0, 3'b001, 32'h101, 32'h0, 32'h00A5F000, 32'h0, 0);
        n_tests++; if (nbeats !== 1 || r_data !== 32'hFFFFA5F0 || r_cyc !== 3) begin
            n_fail++; $display("FAIL lh_off1 got beats=%0d d=%h cyc=%0d exp 1/ffffa5f0/3", nbeats, r_data, r_cyc); end
    endtask

    task automatic test_split_load;
        run32(0, 3'b010, 32'h103, 32'h0, 32'h11223344, 32'h55667788, 0);
        n_tests++; if (nbeats !== 2 || b_addr[0] !== 32'h100 || b_addr[1] !== 32'h104) begin
            n_fail++; $display("FAIL lw_split_addr got beats=%0d a0=%h a1=%h exp 2/00000100/00000104", nbeats, b_addr[0], b_addr[1]); end
        n_tests++; if (r_data !== 32'h66778811 || r_cyc !== 5 || r_fault !== 1'b0) begin
            n_fail++; $display("FAIL lw_split_data got %h cyc=%0d f=%b exp 66778811/5/0", r_data, r_cyc, r_fault); end
    endtask

    task automatic test_split_store;
        run32(1, 3'b001, 32'h1FF, 32'hBEEF, 32'h0, 32'h0, 0);
        n_tests++; if (nbeats !== 2 || b_addr[0] !== 32'h1FC || b_strb[0] !== 4'b1000 || b_wdata[0] !== 32'hEF000000) begin
            n_fail++; $display("FAIL sh_beat0 got beats=%0d addr=%h strb=%b wd=%h exp 2/000001fc/1000/ef000000", nbeats, b_addr[0], b_strb[0], b_wdata[0]); end
        n_tests++; if (b_addr[1] !== 32'h200 || b_strb[1] !== 4'b0001 || b_wdata[1] !== 32'h000000BE || b_we[1] !== 1'b1) begin
            n_fail++; $display("FAIL sh_beat1 got addr=%h strb=%b wd=%h we=%b exp 00000200/0001/000000be/1", b_addr[1], b_strb[1], b_wdata[1], b_we[1]); end
        n_tests++; if (r_cyc !== 5 || r_data !== 32'h0) begin
            n_fail++; $display("FAIL sh_resp got cyc=%0d d=%h exp 5/0", r_cyc, r_data); end
        // Second beat address wraps at the top of the address space.
        run32(1, 3'b010, 32'hFFFFFFFE, 32'hCAFEF00D, 32'h0, 32'h0, 0);
        n_tests++; if (nbeats !== 2 || b_addr[1] !== 32'h0 || b_strb[1] !== 4'b0011 || b_wdata[1] !== 32'h0000CAFE) begin
            n_fail++; $display("FAIL sw_wrap got beats=%0d addr=%h strb=%b wd=%h exp 2/00000000/0011/0000cafe", nbeats, b_addr[1], b_strb[1], b_wdata[1]); end
    endtask

    task automatic test_faults;
        run32(0, 3'b010, 32'h103, 32'h0, 32'h11223344, 32'h55667788, 1);
        n_tests++; if (nbeats !== 1 || r_fault !== 1'b1 || r_data !== 32'h0 || r_cyc !== 3) begin
            n_fail++; $display("FAIL err_beat0 got beats=%0d f=%b d=%h cyc=%0d exp 1/1/0/3", nbeats, r_fault, r_data, r_cyc); end
        run32(0, 3'b011, 32'h100, 32'h0, 32'h0, 32'h0, 0);
        n_tests++; if (nbeats !== 0 || r_fault !== 1'b1 || r_cyc !== 1) begin
            n_fail++; $display("FAIL ld_on_32 got beats=%0d f=%b cyc=%0d exp 0/1/1", nbeats, r_fault, r_cyc); end
        run32(1, 3'b100, 32'h100, 32'h5, 32'h0, 32'h0, 0);
        n_tests++; if (nbeats !== 0 || r_fault !== 1'b1 || r_cyc !== 1) begin
            n_fail++; $display("FAIL sbu_illegal got beats=%0d f=%b cyc=%0d exp 0/1/1", nbeats, r_fault, r_cyc); end
        // No-split variant faults a line-crossing LW immediately.
        @(negedge clk);
        n_req_valid = 1; n_req_store = 0; n_req_funct3 = 3'b010; n_req_addr = 32'h103;
        @(negedge clk);
        n_req_valid = 0;
        n_tests++; if (n_resp_valid !== 1'b1 || n_resp_fault !== 1'b1 || n_mem_req !== 1'b0) begin
            n_fail++; $display("FAIL nosplit_fault got v=%b f=%b req=%b exp 1/1/0", n_resp_valid, n_resp_fault, n_mem_req); end
    endtask

    task automatic test_lwu64;
        @(negedge clk);
        w_req_valid = 1; w_req_store = 0; w_req_funct3 = 3'b110; w_req_addr = 32'h14;
        @(negedge clk);
        w_req_valid = 0;
        n_tests++; if (w_mem_req !== 1'b1 || w_mem_addr !== 32'h10 || w_mem_strb !== 8'h00) begin
            n_fail++; $display("FAIL lwu64_bus got req=%b addr=%h strb=%h exp 1/00000010/00", w_mem_req, w_mem_addr, w_mem_strb); end
        w_mem_gnt = 1;
        @(negedge clk);
        w_mem_gnt = 0; w_mem_rvalid = 1; w_mem_rdata = 64'hFFFFFFFF_00000000;
        @(negedge clk);
        w_mem_rvalid = 0;
        n_tests++; if (w_resp_valid !== 1'b1 || w_resp_rdata !== 64'h00000000FFFFFFFF || w_resp_fault !== 1'b0) begin
            n_fail++; $display("FAIL lwu64_data got v=%b d=%h f=%b exp 1/00000000ffffffff/0", w_resp_valid, w_resp_rdata, w_resp_fault); end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        req_valid = 1; req_store = 0; req_funct3 = 3'b010; req_addr = 32'h200;
        @(negedge clk);
        req_valid = 0;
        n_tests++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL mid_issue got req=%b exp 1", mem_req); end
        mem_gnt = 1;
        @(negedge clk);
        mem_gnt = 0;
        #2 rst_n = 0;
        #1;
        n_tests++; if (mem_req !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset got req=%b ready=%b v=%b exp 0/1/0", mem_req, req_ready, resp_valid); end
        @(negedge clk);
        rst_n = 1;
        mem_rvalid = 1; mem_rdata = 32'h12345678;
        @(negedge clk);
        mem_rvalid = 0;
        n_tests++; if (resp_valid !== 1'b0 || mem_req !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++; $display("FAIL stale_rvalid got v=%b req=%b ready=%b exp 0/0/1", resp_valid, mem_req, req_ready); end
        run32(0, 3'b101, 32'h206, 32'h0, 32'h80010000, 32'h0, 0);
        n_tests++; if (r_data !== 32'h00008001 || r_cyc !== 3 || b_addr[0] !== 32'h204) begin
            n_fail++; $display("FAIL after_reset got d=%h cyc=%0d addr=%h exp 00008001/3/00000204", r_data, r_cyc, b_addr[0]); end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        @(negedge clk);
        rst_n = 1;
        test_sb();
        test_lb_lbu();
        test_split_load();
        test_split_store();
        test_faults();
        test_lwu64();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
